// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard and sequencing controller for the five-stage core.
// Generates freeze (HLT), front-end stall, ID/EX bubble and IF/ID flush
// controls for load-use hazards, multi-cycle MAC occupancy, taken-branch
// redirects and data-memory wait states. Control outputs are combinational
// from state, cnt and the current inputs; the event counters are registered.
module pipe_hazard_ctrl #(
  parameter int unsigned CUS_LAT      = 3,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        RES,
  input  logic [31:0] IF_ID_inst,
  input  logic [31:0] ID_EX_inst,
  input  logic        ID_EX_is_cus,
  input  logic        branch_taken,
  input  logic        MEM_READY,
  output logic        HLT,
  output logic        STALL_FE,
  output logic        BUBBLE_EX,
  output logic        FLUSH_ID,
  output logic [1:0]  ctrl_state,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned CTR_W = 16;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_CUS    = 7'b0001011;

  // A latency/flush length of 1 never leaves RUN, so the reload values are
  // only meaningful for the multi-cycle configurations.
  localparam bit CUS_MULTI   = (CUS_LAT > 1);
  localparam bit FLUSH_MULTI = (FLUSH_CYCLES > 1);
  localparam logic [CNT_W-1:0] CUS_INIT   = CUS_MULTI   ? CNT_W'(CUS_LAT - 2)      : '0;
  localparam logic [CNT_W-1:0] FLUSH_INIT = FLUSH_MULTI ? CNT_W'(FLUSH_CYCLES - 2) : '0;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_LDUSE = 2'd1,
    ST_CUS   = 2'd2,
    ST_FLUSH = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             hlt_c, stall_fe_c, bubble_c, flush_c;
  logic             ld_use_c;
  logic [6:0]       id_op, ex_op;
  logic [4:0]       id_rs2, ex_rd;

  // Only opcode, rs2 and rd take part in the hazard check.
  logic unused_inst_bits;
  assign unused_inst_bits = ^{IF_ID_inst[31:25], IF_ID_inst[19:7], ID_EX_inst[31:12]};

  assign id_op  = IF_ID_inst[6:0];
  assign id_rs2 = IF_ID_inst[24:20];
  assign ex_op  = ID_EX_inst[6:0];
  assign ex_rd  = ID_EX_inst[11:7];

  // Load in EX feeding rs2 of a consumer in ID; rs1 is forwarded by execute.
  always_comb begin
    ld_use_c = 1'b0;
    if ((ex_op == OP_LOAD) && (ex_rd != 5'd0) && (id_rs2 == ex_rd) &&
        ((id_op == OP_OP) || (id_op == OP_BRANCH) ||
         (id_op == OP_STORE) || (id_op == OP_CUS))) begin
      ld_use_c = 1'b1;
    end
  end

  // State and occupancy counter register.
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      state <= ST_RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state and control decode; a memory wait freezes everything.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    hlt_c      = 1'b0;
    stall_fe_c = 1'b0;
    bubble_c   = 1'b0;
    flush_c    = 1'b0;
    if (!MEM_READY) begin
      hlt_c = 1'b1;
    end else begin
      unique case (state)
        ST_RUN: begin
          if (branch_taken) begin
            flush_c  = 1'b1;
            bubble_c = 1'b1;
            if (FLUSH_MULTI) begin
              state_nxt = ST_FLUSH;
              cnt_nxt   = FLUSH_INIT;
            end
          end else if (ID_EX_is_cus && CUS_MULTI) begin
            hlt_c     = 1'b1;
            state_nxt = ST_CUS;
            cnt_nxt   = CUS_INIT;
          end else if (ld_use_c) begin
            stall_fe_c = 1'b1;
            bubble_c   = 1'b1;
            state_nxt  = ST_LDUSE;
          end
        end
        ST_LDUSE: begin
          state_nxt = ST_RUN;
        end
        ST_CUS: begin
          if (cnt != '0) begin
            hlt_c   = 1'b1;
            cnt_nxt = cnt - CNT_W'(1);
          end else begin
            state_nxt = ST_RUN;
          end
        end
        ST_FLUSH: begin
          flush_c  = 1'b1;
          bubble_c = 1'b1;
          if (cnt == '0) begin
            state_nxt = ST_RUN;
          end else begin
            cnt_nxt = cnt - CNT_W'(1);
          end
        end
        default: begin
          state_nxt = ST_RUN;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Saturating stall and flush event counters.
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if ((hlt_c || stall_fe_c) && (stall_cnt != {CTR_W{1'b1}})) begin
        stall_cnt <= stall_cnt + CTR_W'(1);
      end
      if (flush_c && (flush_cnt != {CTR_W{1'b1}})) begin
        flush_cnt <= flush_cnt + CTR_W'(1);
      end
    end
  end

  // Reset forces every control low immediately, independent of the clock.
  assign HLT        = hlt_c      & ~RES;
  assign STALL_FE   = stall_fe_c & ~RES;
  assign BUBBLE_EX  = bubble_c   & ~RES;
  assign FLUSH_ID   = flush_c    & ~RES;
  assign ctrl_state = state;

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline hazard and sequencing controller for the five-stage core. It watches the decode and execute stages and generates the freeze, front-end stall, bubble-insert and flush controls that keep the execute datapath correct. It covers four cases: load-use hazards not covered by execute-stage forwarding, multi-cycle custom multiply-accumulate occupancy, taken-branch/jump redirects, and data-memory wait states. It sits beside `execute` and drives its `HLT` input plus the IF/ID and ID/EX pipeline-register controls.

## Interface
Parameters
- `CUS_LAT`, 3: cycles a custom (MAC) instruction occupies EX; legal 1..15.
- `FLUSH_CYCLES`, 2: cycles of flush/bubble after a redirect; legal 1..3.

Ports
- `CLK`  in  1  single core clock; all state on rising edge.
- `RES`  in  1  reset, asynchronous, active-high.
- `IF_ID_inst`  in  32  instruction currently in decode.
- `ID_EX_inst`  in  32  instruction currently in execute.
- `ID_EX_is_cus`  in  1  execute holds a custom MAC instruction (opcode 0001011).
- `branch_taken`  in  1  execute redirects PC this cycle.
- `MEM_READY`  in  1  data memory ready; low = wait state.
- `HLT`  out  1  freeze PC, IF/ID, ID/EX, EX/MEM registers.
- `STALL_FE`  out  1  hold PC and IF/ID only.
- `BUBBLE_EX`  out  1  load NOP (all-zero) into ID/EX at next edge.
- `FLUSH_ID`  out  1  load NOP into IF/ID at next edge.
- `ctrl_state`  out  2  current state, debug.
- `stall_cnt`  out  16  saturating count of cycles with `HLT` or `STALL_FE` high.
- `flush_cnt`  out  16  saturating count of cycles with `FLUSH_ID` high.

## Operation
- States: RUN=0, LDUSE=1, CUS=2, FLUSH=3. Down-counter `cnt` is 4 bits.
- Global wait: `MEM_READY`=0 forces `HLT`=1 and `STALL_FE`=`BUBBLE_EX`=`FLUSH_ID`=0. State and `cnt` hold. `stall_cnt` increments. All other inputs are ignored that cycle.
- Load-use hazard: `ID_EX_inst[6:0]`=0000011, and `ID_EX_inst[11:7]`≠0, and `IF_ID_inst[6:0]` ∈ {0110011, 1100011, 0100011, 0001011}, and `IF_ID_inst[24:20]`=`ID_EX_inst[11:7]`.
  - Only rs2 is checked. Execute forwards load data to rs1 itself.
- RUN, priority high to low:
  - `branch_taken`: `FLUSH_ID`=`BUBBLE_EX`=1 this cycle. If `FLUSH_CYCLES`>1, go to FLUSH with `cnt`=`FLUSH_CYCLES`-2; otherwise stay in RUN.
  - `ID_EX_is_cus` with `CUS_LAT`>1: `HLT`=1 this cycle; go to CUS with `cnt`=`CUS_LAT`-2.
  - Load-use hazard: `STALL_FE`=`BUBBLE_EX`=1 this cycle; go to LDUSE.
  - Otherwise all controls are 0.
- LDUSE: all controls 0 (the load result is now forwardable); return to RUN. The hazard check is not evaluated in LDUSE, so there is never a back-to-back double stall.
- CUS: `HLT`=1 while `cnt`≠0, decrementing each cycle. When `cnt`=0: `HLT`=0, return to RUN.
- FLUSH: `FLUSH_ID`=`BUBBLE_EX`=1. `branch_taken` is ignored. When `cnt`=0, return to RUN; otherwise decrement.
- Counters saturate at 16'hFFFF and never wrap. They are cleared only by reset.
- Outputs are combinational from state, `cnt` and inputs.

## Timing
- Reset, asynchronous: state=RUN, `cnt`=0, `stall_cnt`=`flush_cnt`=0. While `RES`=1, every output is 0 and `ctrl_state`=0.
- Reset mid-operation aborts any stall or flush immediately. The first post-reset cycle evaluates from RUN.
- Branch redirect: flush asserted in the same cycle as `branch_taken`, for exactly `FLUSH_CYCLES` consecutive non-wait cycles.
- Custom instruction: `HLT` high for exactly `CUS_LAT`-1 non-wait cycles. It starts in the first cycle `ID_EX_is_cus` is seen in RUN.
- Load-use: exactly one cycle of `STALL_FE`+`BUBBLE_EX`. The dependent instruction enters EX two cycles after the load did.
- `MEM_READY` low in CUS or FLUSH stretches that state by the number of wait cycles. During the wait, `HLT`=1, `FLUSH_ID`=`BUBBLE_EX`=0, and `cnt` is frozen.
- Simultaneous branch and load-use in RUN: branch wins, and no LDUSE entry follows.
- `HLT` and `STALL_FE` are never both 1 in the same cycle.

## Test plan
- Reset: assert `RES` mid-CUS (`cnt`=1) → all outputs 0 asynchronously, before the next edge. Release → `ctrl_state`=0 and `stall_cnt`=0.
- Load-use: `ID_EX_inst`=`lw x5,0(x1)`, `IF_ID_inst`=`add x6,x2,x5` → one cycle `STALL_FE`=`BUBBLE_EX`=1, then 0. Repeat with `add x6,x5,x2` (rs1) → no stall. Repeat with rd=x0 → no stall.
- MAC, `CUS_LAT`=3: `ID_EX_is_cus`=1 → `HLT`=1 for 2 cycles, then 0; `stall_cnt`=2. With `CUS_LAT`=1 → `HLT` never asserted.
- Branch, `FLUSH_CYCLES`=2: `branch_taken` pulse → `FLUSH_ID`=`BUBBLE_EX`=1 for cycles 0 and 1, `flush_cnt`=2. A second `branch_taken` in cycle 1 → no extension.
- Wait states: `MEM_READY`=0 for 3 cycles during FLUSH → `HLT`=1 for 3 cycles, then flush resumes for its remaining cycle. The simultaneous load-use + branch case → only flush.
- Saturation: force 70000 wait cycles → `stall_cnt`=16'hFFFF, held there.
